// File: rtl/rv32i_multicycle_sequencer.sv
// Multicycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback
// over one shared memory port, with a memory-timeout fault and retired-instruction counter.
// Optional build macro SEQ_HALT_EN adds a halt_req input and a HALT state entered from WB.
module rv32i_multicycle_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8,
    parameter int unsigned INSTRET_W      = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset,
    input  logic                 memloadf,
    input  logic                 memstoref,
    input  logic                 rd_we,
    input  logic                 mem_ready,
`ifdef SEQ_HALT_EN
    input  logic                 halt_req,
`endif
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 regfile_we,
    output logic                 regfile_insel,
    output logic [2:0]           state,
    output logic                 bus_fault,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5,
        S_HALT   = 3'd6,
        S_RST    = 3'd7
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          cur_state;
    state_t          nxt_state;
    logic [TO_W-1:0] to_cnt;
    logic            to_expire;

    // Expiry is judged on the cycle whose miss would bring the count to TIMEOUT_CYCLES,
    // so a ready in that same cycle still completes the transfer.
    assign to_expire = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_RST:    nxt_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      nxt_state = S_DECODE;
                else if (to_expire) nxt_state = S_FAULT;
            end
            S_DECODE: nxt_state = S_EXEC;
            S_EXEC:   nxt_state = (memloadf || memstoref) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready)      nxt_state = S_WB;
                else if (to_expire) nxt_state = S_FAULT;
            end
`ifdef SEQ_HALT_EN
            S_WB:     nxt_state = halt_req ? S_HALT : S_FETCH;
            S_HALT:   nxt_state = halt_req ? S_HALT : S_FETCH;
`else
            S_WB:     nxt_state = S_FETCH;
            S_HALT:   nxt_state = S_FETCH;
`endif
            S_FAULT:  nxt_state = S_FAULT;
            default:  nxt_state = S_FAULT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            cur_state <= S_RST;
            to_cnt    <= '0;
            instret   <= '0;
        end else begin
            cur_state <= nxt_state;
            // Any cycle without an outstanding miss leaves the counter at zero for the next request.
            to_cnt    <= (mem_req && !mem_ready) ? to_cnt + 1'b1 : '0;
            if (cur_state == S_WB) instret <= instret + 1'b1;
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        regfile_we    = 1'b0;
        regfile_insel = 1'b0;
        bus_fault     = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = memstoref;
            end
            S_WB: begin
                pc_we         = 1'b1;
                regfile_we    = rd_we & ~memstoref;
                regfile_insel = memloadf;
            end
            S_FAULT:  bus_fault = 1'b1;
            default:  ;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_rv32i_multicycle_sequencer.sv
// Directed bench for rv32i_multicycle_sequencer: each cycle's expected outputs are queued
// from a per-state output table and compared against the DUT at the falling edge.
module tb_rv32i_multicycle_sequencer;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3,
                           W = 3'd4, X = 3'd5, H = 3'd6, R = 3'd7;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       sel;
        logic       ir;
        logic       pc;
        logic       rfwe;
        logic       insel;
        logic       flt;
        logic [2:0] cnt;
    } exp_t;

    logic       sys_clk;
    logic       sys_reset;
    logic       memloadf, memstoref, rd_we, mem_ready;
`ifdef SEQ_HALT_EN
    logic       halt_req;
`endif
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, regfile_we, regfile_insel, bus_fault;
    logic [2:0] state;
    logic [2:0] instret;

    int   checks = 0;
    int   errors = 0;
    logic [2:0] icnt;
    exp_t sb[$];

    rv32i_multicycle_sequencer #(
        .TIMEOUT_CYCLES(4),
        .TO_W          (8),
        .INSTRET_W     (3)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_reset    (sys_reset),
        .memloadf     (memloadf),
        .memstoref    (memstoref),
        .rd_we        (rd_we),
        .mem_ready    (mem_ready),
`ifdef SEQ_HALT_EN
        .halt_req     (halt_req),
`endif
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .regfile_we   (regfile_we),
        .regfile_insel(regfile_insel),
        .state        (state),
        .bus_fault    (bus_fault),
        .instret      (instret)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic exp_t expect_of(input logic [2:0] st, input logic rdy);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.cnt = icnt;
        case (st)
            F: begin e.req = 1'b1; e.ir = rdy; end
            M: begin e.req = 1'b1; e.sel = 1'b1; e.we = memstoref; end
            W: begin e.pc = 1'b1; e.rfwe = rd_we & ~memstoref; e.insel = memloadf; end
            X: e.flt = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_now(input string tag);
        exp_t e;
        exp_t o;
        e = sb.pop_front();
        o = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, regfile_we,
             regfile_insel, bus_fault, instret};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // One clock cycle: drive mem_ready, queue the expectation, compare at the falling edge.
    task automatic cyc(input logic [2:0] st, input logic rdy, input string tag);
        mem_ready = rdy;
        sb.push_back(expect_of(st, rdy));
        @(negedge sys_clk);
        check_now(tag);
        if (st == W) icnt = icnt + 3'd1;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_instr(input logic lf, input logic sf, input logic rw);
        memloadf  = lf;
        memstoref = sf;
        rd_we     = rw;
    endtask

    task automatic alu_instr(input string tag);
        set_instr(1'b0, 1'b0, 1'b1);
        cyc(F, 1'b1, tag);
        cyc(D, 1'b1, tag);
        cyc(E, 1'b0, tag);
        cyc(W, 1'b1, tag);
    endtask

    initial begin
        sys_reset = 1'b0;
        mem_ready = 1'b0;
        icnt      = 3'd0;
`ifdef SEQ_HALT_EN
        halt_req  = 1'b0;
`endif
        set_instr(1'b0, 1'b0, 1'b0);
        @(posedge sys_clk);
        #1;
        cyc(R, 1'b1, "reset_state");
        sys_reset = 1'b1;
        cyc(R, 1'b0, "reset_release");

        alu_instr("alu");
        cyc(F, 1'b1, "alu_next_fetch");
        cyc(D, 1'b0, "alu_next_dec");
        cyc(E, 1'b0, "alu_next_exec");
        cyc(W, 1'b0, "alu_next_wb");

        set_instr(1'b1, 1'b0, 1'b1);
        cyc(F, 1'b1, "ld_fetch");
        cyc(D, 1'b0, "ld_dec");
        cyc(E, 1'b0, "ld_exec");
        for (int i = 0; i < 3; i++) cyc(M, 1'b0, "ld_mem_wait");
        cyc(M, 1'b1, "ld_mem_done");
        cyc(W, 1'b0, "ld_wb");

        set_instr(1'b0, 1'b1, 1'b0);
        cyc(F, 1'b1, "st_fetch");
        cyc(D, 1'b0, "st_dec");
        cyc(E, 1'b0, "st_exec");
        cyc(M, 1'b1, "st_mem");
        cyc(W, 1'b0, "st_wb");

        set_instr(1'b1, 1'b1, 1'b1);
        cyc(F, 1'b1, "both_fetch");
        cyc(D, 1'b0, "both_dec");
        cyc(E, 1'b0, "both_exec");
        cyc(M, 1'b1, "both_mem");
        cyc(W, 1'b0, "both_wb");

        set_instr(1'b0, 1'b0, 1'b1);
        cyc(F, 1'b0, "fwait_miss");
        cyc(F, 1'b0, "fwait_miss");
        cyc(F, 1'b1, "fwait_hit");
        cyc(D, 1'b0, "fwait_dec");
        cyc(E, 1'b0, "fwait_exec");
        cyc(W, 1'b0, "fwait_wb");

        for (int i = 0; i < 3; i++) cyc(F, 1'b0, "to_edge_miss");
        cyc(F, 1'b1, "to_edge_hit");
        cyc(D, 1'b0, "to_edge_dec");
        cyc(E, 1'b0, "to_edge_exec");
        cyc(W, 1'b0, "to_edge_wb");

        for (int i = 0; i < 3; i++) alu_instr("wrap_alu");

        for (int i = 0; i < 4; i++) cyc(F, 1'b0, "fetch_timeout_wait");
        cyc(X, 1'b1, "fault_ready_pulse");
        cyc(X, 1'b0, "fault_sticky");
        cyc(X, 1'b1, "fault_ready_pulse2");

        sys_reset = 1'b0;
        icnt      = 3'd0;
        #1;
        sb.push_back(expect_of(R, mem_ready));
        check_now("fault_cleared_by_reset");
        @(posedge sys_clk);
        #1;
        sys_reset = 1'b1;
        cyc(R, 1'b0, "rst2_release");
        alu_instr("post_fault_alu");

        set_instr(1'b1, 1'b0, 1'b1);
        cyc(F, 1'b1, "arst_fetch");
        cyc(D, 1'b0, "arst_dec");
        cyc(E, 1'b0, "arst_exec");
        cyc(M, 1'b0, "arst_mem_wait");
        cyc(M, 1'b0, "arst_mem_wait");
        sys_reset = 1'b0;
        icnt      = 3'd0;
        #1;
        sb.push_back(expect_of(R, mem_ready));
        check_now("async_reset_mid_mem");
        @(posedge sys_clk);
        #1;
        cyc(R, 1'b1, "arst_held");
        sys_reset = 1'b1;
        cyc(R, 1'b0, "arst_release");
        alu_instr("arst_recover_alu");

`ifdef SEQ_HALT_EN
        set_instr(1'b0, 1'b0, 1'b1);
        halt_req = 1'b1;
        cyc(F, 1'b0, "halt_fetch_wait");
        cyc(F, 1'b1, "halt_fetch_hit");
        cyc(D, 1'b0, "halt_dec");
        cyc(E, 1'b0, "halt_exec");
        cyc(W, 1'b0, "halt_wb");
        cyc(H, 1'b1, "halt_hold");
        cyc(H, 1'b0, "halt_hold");
        halt_req = 1'b0;
        cyc(H, 1'b0, "halt_exit");
        alu_instr("halt_resume_alu");
`endif

        set_instr(1'b1, 1'b0, 1'b1);
        cyc(F, 1'b1, "mto_fetch");
        cyc(D, 1'b0, "mto_dec");
        cyc(E, 1'b0, "mto_exec");
        for (int i = 0; i < 4; i++) cyc(M, 1'b0, "mem_timeout_wait");
        cyc(X, 1'b1, "mem_timeout_fault");
        cyc(X, 1'b0, "mem_timeout_sticky");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/rv32i_multicycle_sequencer.md
Name: rv32i_multicycle_sequencer

Overview:
Multicycle control FSM for the RV32I core. It sequences the existing datapath (decoder, ALU, register file, PC register) through fetch, decode, execute, memory and writeback. It owns the single shared memory port, arbitrating between instruction fetch (address = PC) and data load/store (address = ALU result) with a req/ready handshake. It provides a memory-timeout fault and a retired-instruction counter.

Parameters:
TIMEOUT_CYCLES, 255, max wait cycles for mem_ready per request; 0 disables timeout
TO_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES
INSTRET_W, 32, width of retired-instruction counter

Ports:
sys_clk  in  1  system clock, rising edge
sys_reset  in  1  asynchronous, active-low reset
memloadf  in  1  decoder: current instruction is a load
memstoref  in  1  decoder: current instruction is a store
rd_we  in  1  decoder: instruction writes rd (0 for branch/store)
mem_ready  in  1  memory: request completes this cycle
mem_req  out  1  memory request valid
mem_we  out  1  memory write strobe (store only)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  latch instruction register
pc_we  out  1  load next_pc into PC
regfile_we  out  1  register file write enable
regfile_insel  out  1  0 = ALU result, 1 = memory data
state  out  3  current FSM state (debug)
bus_fault  out  1  sticky timeout fault
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5, HALT=6, RST=7.
- Reset (sys_reset low, async): state=RST, instret=0, timeout counter=0, bus_fault=0. All outputs are 0 while in RST.
- Outputs are a Moore decode of state, except ir_we, which also qualifies mem_ready.
- RST -> FETCH on the first clock edge after reset release.
- FETCH: mem_req=1, mem_addr_sel=0. ir_we=mem_ready. On mem_ready go to DECODE; otherwise stay.
- DECODE: one cycle, no strobes. Go to EXEC.
- EXEC: one cycle. If memloadf or memstoref, go to MEM; otherwise go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=memstoref. On mem_ready go to WB; otherwise stay.
- WB: pc_we=1, regfile_we=rd_we & ~memstoref, regfile_insel=memloadf. instret increments by 1 and wraps modulo 2^INSTRET_W. Go to FETCH.
- Handshake: once asserted, mem_req stays high with stable mem_addr_sel/mem_we until a cycle where mem_ready=1. Zero-wait is legal (ready in the first request cycle). mem_ready is ignored when mem_req=0.
- Latency with zero-wait memory: ALU/branch/jump instructions take 4 cycles (FETCH, DECODE, EXEC, WB). Loads/stores take 5. Each wait cycle adds 1.
- Timeout: the counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 && mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES (nonzero), the next state is FAULT.
  - A mem_ready arriving in that same cycle wins: the transfer completes and no fault is raised.
- FAULT: terminal. All strobes are 0 and bus_fault=1. Only reset exits.
- Async reset mid-request drops mem_req immediately. No partial write is retired, since pc_we/regfile_we are only ever asserted in WB.
- memloadf and memstoref both high is illegal. Treat it as a store (mem_we=1, regfile_we=0).

Optional Feature:
SEQ_HALT_EN.
- Defined: adds input port halt_req (1 bit).
  - Sampled in WB. If halt_req=1, the next state is HALT instead of FETCH.
  - HALT: all strobes 0. The FSM leaves HALT to FETCH on the first cycle halt_req=0.
  - halt_req never interrupts an in-flight FETCH or MEM.
- Undefined: the port is absent, the HALT state is unreachable, and WB always goes to FETCH.

Test Plan:
- Reset release, zero-wait memory, ALU instr (rd_we=1) -> state sequence 7,0,1,2,4,0; regfile_we=1 and pc_we=1 only in WB; instret=1.
- Load (memloadf=1), mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with mem_addr_sel=1, mem_we=0; WB has regfile_insel=1; 8 cycles from FETCH to the next FETCH.
- Store (memstoref=1, rd_we=0) -> mem_we=1 only in MEM; regfile_we=0 in WB; instret increments.
- TIMEOUT_CYCLES=4, mem_ready never asserted in FETCH -> FAULT after 4 wait cycles; bus_fault=1 and mem_req=0 thereafter; mem_ready pulses then have no effect. Same setup with mem_ready exactly at the 4th cycle -> DECODE, no fault.
- Assert sys_reset mid-MEM wait -> mem_req drops asynchronously, state=7, instret=0, bus_fault=0; normal fetch after release.
- With SEQ_HALT_EN: halt_req=1 during WB -> HALT (6) with all strobes 0; deassert -> FETCH next cycle, instret unchanged while halted.
